// File: rtl/wimax_pkg.sv
// Shared constants and types for the WiMAX transmit FEC path.
// Generator taps are ordered {u, s1, s2, s3, s4, s5, s6}, MSB first.
package wimax_pkg;

    localparam int unsigned BLOCK_LEN = 96;
    localparam logic [6:0]  G1        = 7'o171;
    localparam logic [6:0]  G2        = 7'o133;

    typedef enum logic [1:0] {IDLE, PRELOAD, ENCODE} enc_state_t;

    function automatic logic cc_tap(input logic [6:0] window, input logic [6:0] gen);
        return ^(window & gen);
    endfunction

endpackage

// File: rtl/fec_pingpong_buf.sv
// Two-bank block buffer: serial write into one bank while the other is read out by index.
// A bank becomes full on its last written bit and is released by the reader.
module fec_pingpong_buf #(
    parameter int unsigned BLOCK_LEN = wimax_pkg::BLOCK_LEN,
    parameter int unsigned PTR_W     = 7
) (
    input  logic             clk,
    input  logic             reset_N,
    input  logic             wr_fire,
    input  logic             wr_bit,
    input  logic             rd_release,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic             wr_full,
    output logic             rd_full,
    output logic             rd_bit,
    output logic [5:0]       rd_tail
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BLOCK_LEN - 1);

    logic [BLOCK_LEN-1:0] bank_q [2];
    logic [1:0]           full_q, full_d;
    logic                 wr_bank_q, rd_bank_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic                 wr_last;

    assign wr_last = wr_fire && (wr_ptr_q == LAST_PTR);
    assign wr_full = full_q[wr_bank_q];
    assign rd_full = full_q[rd_bank_q];
    assign rd_bit  = bank_q[rd_bank_q][rd_ptr];
    // Tail-biting start state: s1..s6 = b95..b90.
    assign rd_tail = bank_q[rd_bank_q][BLOCK_LEN-1 -: 6];

    // Writer and reader always target different banks, so both updates can land together.
    always_comb begin
        full_d = full_q;
        if (wr_last)    full_d[wr_bank_q] = 1'b1;
        if (rd_release) full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_ptr_q  <= '0;
        end else begin
            full_q <= full_d;
            if (rd_release) rd_bank_q <= ~rd_bank_q;
            if (wr_fire) begin
                if (wr_last) begin
                    wr_ptr_q  <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) bank_q[wr_bank_q][wr_ptr_q] <= wr_bit;
    end

endmodule

// File: rtl/fec_cc_encoder.sv
// Rate-1/2 K=7 tail-biting convolutional encoder (171o/133o) over 96-bit blocks.
// Input bits are buffered per block; each block is encoded once its tail bits are known.
module fec_cc_encoder #(
    parameter int unsigned BLOCK_LEN = wimax_pkg::BLOCK_LEN,
    parameter int unsigned PTR_W     = 7
) (
    input  logic       clk,
    input  logic       reset_N,
    input  logic       en,
    input  logic       valid_in,
    input  logic       data_in,
    output logic       ready_fec,
    input  logic       ready_out,
    output logic       valid_out,
    output logic [1:0] data_out,
    output logic       last_out
);

    import wimax_pkg::*;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BLOCK_LEN - 1);

    enc_state_t       state_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [5:0]       sr_q;       // [5]=s1 ... [0]=s6
    logic             wr_full, rd_full, rd_bit;
    logic [5:0]       rd_tail;
    logic             accept, advance, rd_release;
    logic             x_bit, y_bit;

    assign ready_fec  = en && !wr_full;
    assign accept     = en && valid_in && ready_fec;
    assign advance    = en && (state_q == ENCODE) && (!valid_out || ready_out);
    assign rd_release = advance && (rd_ptr_q == LAST_PTR);
    assign x_bit      = cc_tap({rd_bit, sr_q}, G1);
    assign y_bit      = cc_tap({rd_bit, sr_q}, G2);

    fec_pingpong_buf #(
        .BLOCK_LEN (BLOCK_LEN),
        .PTR_W     (PTR_W)
    ) u_buf (
        .clk        (clk),
        .reset_N    (reset_N),
        .wr_fire    (accept),
        .wr_bit     (data_in),
        .rd_release (rd_release),
        .rd_ptr     (rd_ptr_q),
        .wr_full    (wr_full),
        .rd_full    (rd_full),
        .rd_bit     (rd_bit),
        .rd_tail    (rd_tail)
    );

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            sr_q      <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            last_out  <= 1'b0;
        end else if (en) begin
            // Drain on consume; overridden below if a new pair is registered.
            if (ready_out) valid_out <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rd_full) state_q <= PRELOAD;
                end
                PRELOAD: begin
                    sr_q     <= rd_tail;
                    rd_ptr_q <= '0;
                    state_q  <= ENCODE;
                end
                ENCODE: begin
                    if (advance) begin
                        data_out  <= {x_bit, y_bit};
                        valid_out <= 1'b1;
                        last_out  <= (rd_ptr_q == LAST_PTR);
                        sr_q      <= {rd_bit, sr_q[5:1]};
                        rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
                        if (rd_ptr_q == LAST_PTR) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fec_cc_encoder.sv
// Bench for fec_cc_encoder: directed blocks, expected pairs queued at stimulus time,
// a monitor pops and compares on every consumed pair.
module tb_fec_cc_encoder;

    localparam logic [95:0]  GOLD_IN  = 96'h558AC4A53A1724E163AC2BF9;
    localparam logic [191:0] GOLD_OUT = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;
    localparam logic [95:0]  IMP_IN   = {1'b1, 95'h0};
    localparam logic [191:0] IMP_OUT  = {16'hEF1C, 176'h0};

    logic       clk;
    logic       reset_N;
    logic       en;
    logic       valid_in;
    logic       data_in;
    logic       ready_fec;
    logic       ready_out;
    logic       valid_out;
    logic [1:0] data_out;
    logic       last_out;

    int         n_cmp;
    int         n_err;
    logic [2:0] exp_q [$];
    logic       rand_ready;
    logic       measure;
    int         low_run;
    int         max_low;

    fec_cc_encoder dut (
        .clk       (clk),
        .reset_N   (reset_N),
        .en        (en),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_fec (ready_fec),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .last_out  (last_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic push_block(input logic [191:0] e);
        for (int k = 0; k < 96; k++)
            exp_q.push_back({e[191-2*k], e[190-2*k], (k == 95)});
    endtask

    // Called and returns just after a rising edge.
    task automatic en_gap();
        logic [3:0] snap;
        en = 1'b0;
        snap = {valid_out, data_out, last_out};
        repeat (10) begin
            @(posedge clk);
            #1;
            check("gap_hold", {valid_out, data_out, last_out}, snap);
            check("gap_ready_fec", ready_fec, 0);
        end
        en = 1'b1;
    endtask

    task automatic send_bits(input logic [95:0] blk, input int nbits, input int gap_at);
        logic accepted;
        int   w;
        for (int i = 0; i < nbits; i++) begin
            valid_in = 1'b1;
            data_in  = blk[95-i];
            if (i == gap_at) en_gap();
            accepted = 1'b0;
            w = 0;
            while (!accepted) begin
                @(negedge clk);
                accepted = en && ready_fec;
                @(posedge clk);
                #1;
                w++;
                if (!accepted && w > 400) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL accept_timeout: bit %0d not accepted, want accept within 400 cycles", i);
                    valid_in = 1'b0;
                    return;
                end
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 3000) begin
            @(posedge clk);
            w++;
        end
        #1;
        check({name, "_drain_left"}, exp_q.size(), 0);
        @(negedge clk);
        check({name, "_idle_valid"}, valid_out, 0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pair compare on consume, hold check while stalled.
    initial begin
        logic       hold_prev;
        logic [2:0] prev;
        logic [2:0] want;
        hold_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!reset_N) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) check("hold_stable", {data_out, last_out}, prev);
                if (en && valid_out && ready_out) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_pair: got %b want no pair", {data_out, last_out});
                    end else begin
                        want = exp_q.pop_front();
                        check("pair", {data_out, last_out}, want);
                    end
                end
                hold_prev = valid_out && !ready_out;
                prev = {data_out, last_out};
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) ready_out = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (measure) begin
                if (!ready_fec) begin
                    low_run++;
                    if (low_run > max_low) max_low = low_run;
                end else begin
                    low_run = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_N = 1'b0;
        en = 1'b0;
        valid_in = 1'b0;
        data_in = 1'b0;
        ready_out = 1'b1;
        rand_ready = 1'b0;
        measure = 1'b0;
        low_run = 0;
        max_low = 0;

        #12;
        check("rst_valid_out", valid_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_last_out", last_out, 0);
        check("rst_ready_fec_en_low", ready_fec, 0);
        en = 1'b1;
        #1;
        check("rst_ready_fec_en_high", ready_fec, 1);
        @(negedge clk);
        reset_N = 1'b1;
        @(posedge clk);
        #1;

        // Single golden block.
        push_block(GOLD_OUT);
        send_bits(GOLD_IN, 96, -1);
        drain("gold");

        // Back-to-back blocks, ready_out held high.
        measure = 1'b1;
        push_block(IMP_OUT);
        send_bits(IMP_IN, 96, -1);
        push_block({192{1'b1}});
        send_bits({96{1'b1}}, 96, -1);
        push_block(192'h0);
        send_bits(96'h0, 96, -1);
        push_block(GOLD_OUT);
        send_bits(GOLD_IN, 96, -1);
        measure = 1'b0;
        drain("b2b");
        check("ready_fec_low_run_le2", (max_low <= 2), 1);

        // Three golden blocks with random output backpressure.
        rand_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            push_block(GOLD_OUT);
            send_bits(GOLD_IN, 96, -1);
        end
        drain("rand");
        rand_ready = 1'b0;
        ready_out = 1'b1;
        @(posedge clk);
        #1;

        // Enable gaps mid-fill and mid-encode.
        push_block(GOLD_OUT);
        send_bits(GOLD_IN, 96, 50);
        repeat (20) @(posedge clk);
        #1;
        en_gap();
        drain("engap");

        // Reset mid-stream: one block stalled in encode, 40 bits of the next written.
        ready_out = 1'b0;
        push_block(GOLD_OUT);
        send_bits(GOLD_IN, 96, -1);
        send_bits(GOLD_IN, 40, -1);
        check("pre_reset_valid", valid_out, 1);
        #2;
        reset_N = 1'b0;
        #1;
        check("async_rst_valid_out", valid_out, 0);
        check("async_rst_data_out", data_out, 0);
        check("async_rst_last_out", last_out, 0);
        check("async_rst_ready_fec", ready_fec, 1);
        exp_q.delete();
        #9;
        reset_N = 1'b1;
        @(posedge clk);
        #1;
        ready_out = 1'b1;
        push_block(GOLD_OUT);
        send_bits(GOLD_IN, 96, -1);
        drain("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
